// File: rtl/ram_march_bist_pkg.sv
// Shared types for the March C- RAM BIST: FSM states, element descriptors
// and the constant element table walked by the controller.
package ram_bist_pkg;

  localparam int unsigned FAIL_CNT_W = 16;
  localparam int unsigned NUM_ELEMS  = 6;

  typedef enum logic [2:0] {
    StIdle,
    StRdIssue,
    StRdWait,
    StWrite,
    StNextElem,
    StFinish
  } state_e;

  // One march element; "inv" selects ~PATTERN instead of PATTERN.
  typedef struct packed {
    logic dir_down;
    logic do_read;
    logic do_write;
    logic read_expect_inv;
    logic write_inv;
  } elem_t;

  // M0 up w0; M1 up r0 w1; M2 up r1 w0; M3 down r0 w1; M4 down r1 w0; M5 down r0
  localparam elem_t ELEM_TABLE [NUM_ELEMS] = '{
    '{dir_down: 1'b0, do_read: 1'b0, do_write: 1'b1, read_expect_inv: 1'b0, write_inv: 1'b0},
    '{dir_down: 1'b0, do_read: 1'b1, do_write: 1'b1, read_expect_inv: 1'b0, write_inv: 1'b1},
    '{dir_down: 1'b0, do_read: 1'b1, do_write: 1'b1, read_expect_inv: 1'b1, write_inv: 1'b0},
    '{dir_down: 1'b1, do_read: 1'b1, do_write: 1'b1, read_expect_inv: 1'b0, write_inv: 1'b1},
    '{dir_down: 1'b1, do_read: 1'b1, do_write: 1'b1, read_expect_inv: 1'b1, write_inv: 1'b0},
    '{dir_down: 1'b1, do_read: 1'b1, do_write: 1'b0, read_expect_inv: 1'b0, write_inv: 1'b0}
  };

  // Out-of-range indices never occur in a run; they decode to an inert element.
  function automatic elem_t elem_lookup(input logic [2:0] idx);
    if (idx < 3'(NUM_ELEMS)) return ELEM_TABLE[idx];
    return '0;
  endfunction

endpackage

// File: rtl/ram_march_bist_if.sv
// RAM port bundle driven by the BIST (master) and served by the RAM (slave).
interface ram_march_bist_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 16
);
  logic              mem_load;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data_in;
  logic [DATA_W-1:0] mem_data_out;

  modport master (output mem_load, output mem_address, output mem_data_in, input mem_data_out);
  modport slave  (input mem_load, input mem_address, input mem_data_in, output mem_data_out);
endinterface

// File: rtl/ram_march_bist_addr_gen.sv
// Loadable up/down address counter; init loads 0 (up) or N-1 (down) and
// last flags the terminal address of the current direction.
module bist_addr_gen #(
  parameter int unsigned ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init,
  input  logic              init_down,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic              down_q;
  logic [ADDR_W-1:0] addr_q;

  // Direction is captured at init so stepping needs no external context.
  always_ff @(posedge clk) begin
    if (rst) begin
      down_q <= 1'b0;
      addr_q <= '0;
    end else if (init) begin
      down_q <= init_down;
      addr_q <= init_down ? '1 : '0;
    end else if (step) begin
      addr_q <= down_q ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1);
    end
  end

  assign addr = addr_q;
  assign last = down_q ? (addr_q == '0) : (addr_q == '1);

endmodule

// File: rtl/ram_march_bist.sv
// March C- BIST initiator: walks the element table over the full RAM,
// compares read data against the background pattern and records results.
module ram_march_bist #(
  parameter int unsigned       ADDR_W  = 12,
  parameter int unsigned       DATA_W  = 16,
  parameter int unsigned       RD_LAT  = 1,
  parameter logic [DATA_W-1:0] PATTERN = 16'h5555
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [15:0]           fail_count,
  output logic [ADDR_W-1:0]     fail_addr,
  output logic [2:0]            fail_elem,
  output logic [DATA_W-1:0]     fail_data,
  ram_march_bist_if.master      mem
);
  import ram_bist_pkg::*;

  localparam logic [DATA_W-1:0] BG0 = PATTERN;
  localparam logic [DATA_W-1:0] BG1 = ~PATTERN;

  state_e                state_q, state_d;
  logic [2:0]            elem_q, elem_d;
  logic                  busy_q, done_q, pass_q;
  logic [FAIL_CNT_W-1:0] fail_cnt_q, fail_cnt_d;
  logic [ADDR_W-1:0]     fail_addr_q;
  logic [2:0]            fail_elem_q;
  logic [DATA_W-1:0]     fail_data_q;

  logic              ag_init, ag_init_down, ag_step, ag_last;
  logic [ADDR_W-1:0] addr;
  logic              cmp_en, op_done, start_run, mismatch;
  elem_t             cur, nxt;
  logic [DATA_W-1:0] exp_val;

  bist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .init      (ag_init),
    .init_down (ag_init_down),
    .step      (ag_step),
    .addr      (addr),
    .last      (ag_last)
  );

  assign cur     = elem_lookup(elem_q);
  assign nxt     = elem_lookup(elem_q + 3'd1);
  assign exp_val = cur.read_expect_inv ? BG1 : BG0;

  // Sequencing: per-address op order, then element advance or finish.
  always_comb begin
    state_d      = state_q;
    elem_d       = elem_q;
    ag_init      = 1'b0;
    ag_init_down = 1'b0;
    ag_step      = 1'b0;
    cmp_en       = 1'b0;
    op_done      = 1'b0;
    start_run    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          start_run    = 1'b1;
          elem_d       = 3'd0;
          ag_init      = 1'b1;
          ag_init_down = elem_lookup(3'd0).dir_down;
          state_d      = elem_lookup(3'd0).do_read ? StRdIssue : StWrite;
        end
      end
      StRdIssue: begin
        if (RD_LAT != 0) begin
          state_d = StRdWait;
        end else begin
          cmp_en = 1'b1;
          if (cur.do_write) state_d = StWrite;
          else              op_done = 1'b1;
        end
      end
      StRdWait: begin
        cmp_en = 1'b1;
        if (cur.do_write) state_d = StWrite;
        else              op_done = 1'b1;
      end
      StWrite:    op_done = 1'b1;
      StNextElem: state_d = cur.do_read ? StRdIssue : StWrite;
      StFinish:   state_d = StIdle;
      default:    state_d = StIdle;
    endcase

    if (op_done) begin
      if (ag_last) begin
        if (elem_q == 3'(NUM_ELEMS - 1)) begin
          state_d = StFinish;
        end else begin
          state_d      = StNextElem;
          elem_d       = elem_q + 3'd1;
          ag_init      = 1'b1;
          ag_init_down = nxt.dir_down;
        end
      end else begin
        ag_step = 1'b1;
        state_d = cur.do_read ? StRdIssue : StWrite;
      end
    end
  end

  assign mismatch = cmp_en && (mem.mem_data_out != exp_val);

  // Saturating mismatch counter next value.
  always_comb begin
    fail_cnt_d = fail_cnt_q;
    if (mismatch && (fail_cnt_q != '1)) fail_cnt_d = fail_cnt_q + FAIL_CNT_W'(1);
  end

  // FSM state plus registered busy/done derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      elem_q  <= 3'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      busy_q  <= (state_d != StIdle);
      done_q  <= (state_d == StFinish);
    end
  end

  // Result registers: cleared on start, first mismatch latched, pass set entering FINISH.
  always_ff @(posedge clk) begin
    if (rst || start_run) begin
      pass_q      <= 1'b0;
      fail_cnt_q  <= '0;
      fail_addr_q <= '0;
      fail_elem_q <= 3'd0;
      fail_data_q <= '0;
    end else begin
      fail_cnt_q <= fail_cnt_d;
      if (mismatch && (fail_cnt_q == '0)) begin
        fail_addr_q <= addr;
        fail_elem_q <= elem_q;
        fail_data_q <= mem.mem_data_out;
      end
      if (state_d == StFinish) pass_q <= (fail_cnt_d == '0);
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_count = fail_cnt_q;
  assign fail_addr  = fail_addr_q;
  assign fail_elem  = fail_elem_q;
  assign fail_data  = fail_data_q;

  // RAM port is decoded from registered state only; read data never reaches it.
  assign mem.mem_load    = (state_q == StWrite);
  assign mem.mem_address = (state_q == StIdle) ? '0 : addr;
  assign mem.mem_data_in = (state_q == StWrite) ? (cur.write_inv ? BG1 : BG0) : '0;

endmodule

// File: doc/ram_march_bist.md
# ram_march_bist

Built-in self-test initiator for the Hack data RAM (ram4k-class memories). It drives a RAM's load/address/data_in port and checks data_out. On `start` it runs a March C- sequence over the full address space with a configurable background pattern, then reports pass/fail, the error count and the first failing location. It sits between the boot/reset controller and the RAM port mux and owns the RAM port only while `busy`.

## Interface
- `ADDR_W`, 12: RAM address width; N = 2**ADDR_W words.
- `DATA_W`, 16: RAM word width.
- `RD_LAT`, 1: RAM read latency in cycles; legal values 0 (combinational data_out) or 1 (registered).
- `PATTERN`, 16'h5555: background "0" value; "1" is ~PATTERN.

- `clk` in 1: single clock, all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `start` in 1: begin test; sampled only when `busy`=0.
- `busy` out 1: test running; BIST owns the RAM port.
- `done` out 1: one-cycle pulse at end of test.
- `pass` out 1: 1 when the last completed test had 0 mismatches; held until next start.
- `fail_count` out 16: mismatch count, saturating at 16'hFFFF.
- `fail_addr` out ADDR_W: address of first mismatch.
- `fail_elem` out 3: march element index (0–5) of first mismatch.
- `fail_data` out DATA_W: data_out value read at first mismatch.
- `mem_load` out 1: RAM write enable.
- `mem_address` out ADDR_W: RAM address.
- `mem_data_in` out DATA_W: RAM write data.
- `mem_data_out` in DATA_W: RAM read data.

## Operation
- Elements (0 = PATTERN, 1 = ~PATTERN):
  - M0: up, w0.
  - M1: up, r0 w1.
  - M2: up, r1 w0.
  - M3: down, r0 w1.
  - M4: down, r1 w0.
  - M5: down, r0.
- FSM states: IDLE, RD_ISSUE, RD_WAIT (only when RD_LAT=1), WRITE, NEXT_ELEM, FINISH.
- Per address: r-then-w elements go RD_ISSUE → [RD_WAIT] → WRITE. Read-only elements go RD_ISSUE → [RD_WAIT]. Write-only elements go WRITE.
- Read: `mem_load`=0 and `mem_address`=A, held through RD_WAIT. `mem_data_out` is compared on the edge ending RD_ISSUE (RD_LAT=0) or the edge ending RD_WAIT (RD_LAT=1).
- Mismatch handling:
  - `fail_count` increments, saturating.
  - The first mismatch of a run latches `fail_addr`/`fail_elem`/`fail_data`. Later mismatches do not update them.
  - The test always runs to completion.
- Write: `mem_load`=1 for exactly one cycle with A and the element's write value.
- Address counter: up elements run 0→N-1. Down elements run N-1→0. The terminal address ends the element without wrapping.
- On `start`, all result outputs clear to 0 (pass=0), the address counter loads 0, and the FSM enters M0.
- FINISH: `done`=1 for one cycle, `pass`=(fail_count==0), `busy`=0, then IDLE.
- `start` while busy=1 is ignored. `start` held high in the FINISH cycle is ignored. `start` held high in IDLE afterwards starts a new run.
- Outside write cycles, `mem_load`=0 and `mem_data_in`=0. In IDLE, `mem_address`=0.

## Timing
- Reset values: every output is 0, the FSM is in IDLE, and the counters are 0. `rst` asserted mid-test forces this state at the next edge; there is no partial result.
- `busy` rises on the edge after `start` is sampled.
- First RAM operation (M0 w0 to address 0) occurs in the first busy cycle.
- Busy cycles: N + 4·(2+RD_LAT)·N + (1+RD_LAT)·N, plus one NEXT_ELEM cycle per element boundary (5), plus FINISH. For N=16 this is 240+5+1=246 (RD_LAT=1) or 160+5+1=166 (RD_LAT=0).
- `done` is coincident with the FINISH cycle. `pass`/`fail_*` are stable from that cycle on.
- No combinational path from `mem_data_out` to any output. All outputs are registered.

## Structure
- Package `ram_bist_pkg`:
  - state enum;
  - element descriptor struct (direction, do_read, do_write, read_expect_inv, write_inv);
  - constant 6-entry element table;
  - `FAIL_CNT_W`=16.
- Sub-module `bist_addr_gen`: loadable up/down ADDR_W counter with a `last` flag and an `init(dir)` input; it loads 0 for up and N-1 for down.
- Top: FSM, comparator, result registers.

## Test plan
1. Fault-free RAM model, ADDR_W=4, RD_LAT=1, PATTERN=16'h5555 → busy for 246 cycles, one `done` pulse, pass=1, fail_count=0, exactly 80 `mem_load` pulses.
2. Model with bit0 of address 5 stuck-at-0 → fail_count=3 (reads of 0 in M1, M3, M5), fail_addr=5, fail_elem=1, fail_data=16'h5554, pass=0.
3. Address order check, same setup as scenario 1 → M0 writes hit 0,1,…,15; M3's first read is address 15 and its addresses descend to 0.
4. RD_LAT=0 with a combinational RAM model → busy for 166 cycles, pass=1.
5. Assert `rst` for 1 cycle at busy cycle 50 → next edge: busy=0, mem_load=0, fail_count=0. A new `start` then completes with pass=1.
6. Pulse `start` repeatedly while busy → no restart, identical cycle count and results to scenario 1.
